// File: rtl/vpu_cmd_queue.sv
// Host command FIFO in front of the VPU request port. It holds commands back
// per stream while that stream has MAX_OUTSTANDING responses still pending.
module vpu_cmd_queue #(
  parameter int STREAM_ID_WIDTH = 2,
  parameter int DEPTH           = 4,
  parameter int DEPTH_LG2       = 2,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       host_valid_i,
  output logic                       host_ready_o,
  input  logic [7:0]                 host_opcode_i,
  input  logic [23:0]                host_dst0_i,
  input  logic [23:0]                host_src0_i,
  input  logic [23:0]                host_src1_i,
  input  logic [23:0]                host_src2_i,
  input  logic [23:0]                host_imm_i,
  input  logic [STREAM_ID_WIDTH-1:0] host_stream_id_i,
  output logic                       vpu_valid_o,
  input  logic                       vpu_ready_i,
  output logic [7:0]                 vpu_opcode_o,
  output logic [23:0]                vpu_dst0_o,
  output logic [23:0]                vpu_src0_o,
  output logic [23:0]                vpu_src1_o,
  output logic [23:0]                vpu_src2_o,
  output logic [23:0]                vpu_imm_o,
  output logic [STREAM_ID_WIDTH-1:0] vpu_stream_id_o,
  input  logic                       mon_resp_valid_i,
  input  logic                       mon_resp_ready_i,
  input  logic [STREAM_ID_WIDTH-1:0] mon_resp_stream_id_i,
  output logic [DEPTH_LG2:0]         occupancy_o,
  output logic                       idle_o,
  output logic                       err_o
);

  localparam int               NUM_STREAMS = 1 << STREAM_ID_WIDTH;
  localparam int               ENTRY_W     = 8 + 5 * 24 + STREAM_ID_WIDTH;
  localparam logic [2:0]       MAX_OS      = 3'(MAX_OUTSTANDING);
  localparam logic [DEPTH_LG2:0] DEPTH_CNT = (DEPTH_LG2 + 1)'(DEPTH);

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [DEPTH_LG2-1:0] wr_ptr;
  logic [DEPTH_LG2-1:0] rd_ptr;
  logic [DEPTH_LG2:0]   occ;
  logic [2:0]           inflight [NUM_STREAMS];
  logic                 err;

  logic [ENTRY_W-1:0]   host_entry;
  logic [ENTRY_W-1:0]   head_entry;
  logic                 push;
  logic                 pop;
  logic                 resp;
  logic                 inc [NUM_STREAMS];
  logic                 dec [NUM_STREAMS];
  logic                 all_zero;

  assign host_entry = {host_opcode_i, host_dst0_i, host_src0_i, host_src1_i,
                       host_src2_i, host_imm_i, host_stream_id_i};
  assign head_entry = mem[rd_ptr];
  assign {vpu_opcode_o, vpu_dst0_o, vpu_src0_o, vpu_src1_o,
          vpu_src2_o, vpu_imm_o, vpu_stream_id_o} = head_entry;

  // No bypass: a full queue refuses a push even while it pops.
  assign host_ready_o = (occ < DEPTH_CNT);
  assign vpu_valid_o  = (occ != '0) && (inflight[vpu_stream_id_o] < MAX_OS);

  assign push = host_valid_i & host_ready_o;
  assign pop  = vpu_valid_o & vpu_ready_i;
  assign resp = mon_resp_valid_i & mon_resp_ready_i;

  assign occupancy_o = occ;
  assign err_o       = err;
  assign idle_o      = (occ == '0) && all_zero;

  always_comb begin
    all_zero = 1'b1;
    for (int s = 0; s < NUM_STREAMS; s++) begin
      inc[s] = pop  && (vpu_stream_id_o == STREAM_ID_WIDTH'(s));
      dec[s] = resp && (mon_resp_stream_id_i == STREAM_ID_WIDTH'(s));
      if (inflight[s] != 3'd0) all_zero = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      for (int s = 0; s < NUM_STREAMS; s++) inflight[s] <= 3'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= host_entry;
        wr_ptr      <= wr_ptr + DEPTH_LG2'(1);
      end
      if (pop) rd_ptr <= rd_ptr + DEPTH_LG2'(1);

      case ({push, pop})
        2'b10:   occ <= occ + (DEPTH_LG2 + 1)'(1);
        2'b01:   occ <= occ - (DEPTH_LG2 + 1)'(1);
        default: occ <= occ;
      endcase

      // A response with nothing outstanding is flagged, never underflowed.
      for (int s = 0; s < NUM_STREAMS; s++) begin
        if (inc[s] && !dec[s])
          inflight[s] <= inflight[s] + 3'd1;
        else if (dec[s] && !inc[s] && (inflight[s] != 3'd0))
          inflight[s] <= inflight[s] - 3'd1;
      end

      if (resp && (inflight[mon_resp_stream_id_i] == 3'd0)) err <= 1'b1;
    end
  end

endmodule

// File: doc/vpu_cmd_queue.md
Name: vpu_cmd_queue

Overview:
Host-side command buffer directly upstream of the VPU top request interface. It accepts host commands (opcode, dst0, src0, src1, src2, imm, stream ID) into a DEPTH-entry FIFO and issues them to the VPU over valid/ready. It snoops the VPU response handshake to keep a per-stream in-flight count and stalls dispatch of a stream that has MAX_OUTSTANDING commands in flight.

Parameters:
STREAM_ID_WIDTH, 2, stream ID width; 2**STREAM_ID_WIDTH streams.
DEPTH, 4, FIFO entries; power of two, at least 2.
DEPTH_LG2, 2, log2(DEPTH).
MAX_OUTSTANDING, 3, per-stream in-flight limit, from 1 to 7. In-flight counters are 3 bits.

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
host_valid_i  in  1  host command valid.
host_ready_o  out  1  queue can accept a command.
host_opcode_i  in  8  opcode.
host_dst0_i / host_src0_i / host_src1_i / host_src2_i / host_imm_i  in  24 each  operand fields.
host_stream_id_i  in  STREAM_ID_WIDTH  command stream.
vpu_valid_o  out  1  head command valid toward VPU (drives VPU valid_i).
vpu_ready_i  in  1  VPU ready_o.
vpu_opcode_o, vpu_dst0_o, vpu_src0_o, vpu_src1_o, vpu_src2_o, vpu_imm_o, vpu_stream_id_o  out  same widths  head entry fields.
mon_resp_valid_i  in  1  copy of the VPU resp_valid_o.
mon_resp_ready_i  in  1  copy of the host resp_ready_i.
mon_resp_stream_id_i  in  STREAM_ID_WIDTH  copy of the VPU resp_stream_id_o.
occupancy_o  out  DEPTH_LG2+1  FIFO entry count.
idle_o  out  1  FIFO empty and all in-flight counters at zero.
err_o  out  1  sticky protocol error.

Behaviour:
- Reset: synchronous, active-high. Clears the FIFO pointers, occupancy, all in-flight counters and err_o. Reset values: host_ready_o=1, vpu_valid_o=0, occupancy_o=0, idle_o=1, err_o=0. Data outputs are don't-care, but the bench expects 0.
- Reset mid-operation discards all queued commands and in-flight counts. No VPU handshake is generated in the reset cycle.
- FIFO storage: DEPTH registers of 130 bits (8 + 5×24 + STREAM_ID_WIDTH at default). Read and write pointers are DEPTH_LG2 bits and wrap modulo DEPTH. A separate occupancy counter is DEPTH_LG2+1 bits.
- push = host_valid_i & host_ready_o.
- host_ready_o = (occupancy < DEPTH). When full, a push is refused even in a cycle that pops (no same-cycle bypass).
- Head fields drive the vpu_*_o outputs directly from FIFO storage at the read pointer (first-word fall-through).
- Minimum latency: a push in cycle N gives vpu_valid_o=1 in cycle N+1.
- vpu_valid_o = (occupancy != 0) & (inflight[head stream] < MAX_OUTSTANDING).
- pop = vpu_valid_o & vpu_ready_i.
- Handshake rule: once vpu_valid_o is asserted, the head fields are stable until pop. The head cannot change without a pop. The in-flight count for the head stream can only decrease while waiting, so vpu_valid_o never falls without a pop, except on reset.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance. Push into an empty queue makes the entry visible next cycle, never the same cycle.
- resp = mon_resp_valid_i & mon_resp_ready_i.
- In-flight counter per stream s:
  - pop on s and no resp on s: +1.
  - resp on s and no pop on s: −1.
  - pop and resp both on s in the same cycle: unchanged.
- A resp on stream s while inflight[s]==0: counter stays 0 and err_o sets. err_o clears only on reset.
- A pop can never take inflight beyond MAX_OUTSTANDING; this is guaranteed by the vpu_valid_o gating.
- Head-of-line blocking is intended. A stalled head stream blocks later commands of other streams, which preserves global issue order.
- occupancy_o and idle_o are registered-state derived; they reflect the state after the previous edge.

Test Plan:
- Reset, then push 4 commands (stream IDs 0,1,2,3; opcode 0x10..0x13) with vpu_ready_i=0 → occupancy_o=4, host_ready_o=0; a 5th host_valid_i is not accepted; head shows opcode 0x10.
- Set vpu_ready_i=1 with no responses → commands drain in order 0x10..0x13, one per cycle; afterwards inflight is 1 for each stream, idle_o=0.
- Push 4 commands, all stream 2, with vpu_ready_i=1 held → 3 pops, then vpu_valid_o=0 with the 4th at the head. One response on stream 2 → the 4th pops the next cycle.
- Full queue with push and pop in the same cycle → push refused, occupancy goes 4→3. Then at occupancy 2, simultaneous push and pop → occupancy stays 2 and the pointers wrap correctly over 10 cycles of streaming.
- Response on stream 1 while inflight[1]=0 → err_o=1 and stays 1; inflight[1] stays 0. Pop and response on stream 0 in the same cycle → inflight[0] unchanged.
- Assert rst with 3 queued and 2 in flight → next cycle occupancy_o=0, idle_o=1, vpu_valid_o=0, err_o=0.
